// File: rtl/instream.sv
// instream: test-vector stream source offering words over a ready/read handshake.
// Optional INSTREAM_STALL_EN adds a saturating consumer back-pressure counter (stall_cnt).
`default_nettype none

module instream #(
    parameter int DEPTH = 39,
    parameter int LEN_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LEN_W-1:0]         length,
    input  logic signed [10:0]       data [0:DEPTH-1],
    input  logic                     rd,
    output logic                     wready,
    output logic signed [10:0]       value,
    output logic [LEN_W-1:0]         pos,
    output logic                     range_err,
    output logic                     complete
`ifdef INSTREAM_STALL_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_OFFER = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      pos_d;
    logic [LEN_W-1:0]      next_idx;
    logic [LEN_W-1:0]      len_clamped;
    logic signed [10:0]    value_d;
    logic signed [10:0]    load_word;
    logic signed [10:0]    load_sat;
    logic                  load_en;
    logic                  wready_d;
    logic                  complete_d;
    logic                  err_d;

    function automatic logic signed [10:0] sat(input logic signed [10:0] x);
        if (x > 11'sd999)
            return 11'sd999;
        else if (x < -11'sd999)
            return -11'sd999;
        else
            return x;
    endfunction

    assign len_clamped = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
    assign next_idx    = pos + LEN_W'(1);
    assign load_sat    = sat(load_word);

    always_comb begin
        state_d    = state;
        len_d      = len_q;
        pos_d      = pos;
        value_d    = value;
        wready_d   = wready;
        complete_d = complete;
        err_d      = range_err;
        load_en    = 1'b0;
        load_word  = '0;
        case (state)
            S_LOAD: begin
                len_d = len_clamped;
                if (len_clamped == '0) begin
                    state_d    = S_DONE;
                    complete_d = 1'b1;
                end else begin
                    load_en   = 1'b1;
                    load_word = data[0];
                    wready_d  = 1'b1;
                    state_d   = S_OFFER;
                end
            end
            S_OFFER: begin
                if (rd) begin
                    pos_d = next_idx;
                    if (next_idx == len_q) begin
                        state_d    = S_DONE;
                        wready_d   = 1'b0;
                        complete_d = 1'b1;
                    end else begin
                        // next_idx < len_q <= DEPTH here, so the index is in range
                        load_en   = 1'b1;
                        load_word = data[next_idx];
                    end
                end
            end
            S_DONE: begin
            end
            default: state_d = S_LOAD;
        endcase
        if (load_en) begin
            value_d = load_sat;
            if (load_sat != load_word)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            len_q     <= '0;
            pos       <= '0;
            value     <= '0;
            wready    <= 1'b0;
            complete  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_d;
            len_q     <= len_d;
            pos       <= pos_d;
            value     <= value_d;
            wready    <= wready_d;
            complete  <= complete_d;
            range_err <= err_d;
        end
    end

`ifdef INSTREAM_STALL_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == S_OFFER && !rd && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instream.sv
// tb_instream: scoreboard bench for instream; expected words are queued as data is set up.
`default_nettype none

module tb_instream;

    localparam int DEPTH = 39;
    localparam int LEN_W = 6;

    logic                  clk;
    logic                  rst;
    logic [LEN_W-1:0]      length;
    logic signed [10:0]    data [0:DEPTH-1];
    logic                  rd;
    logic                  wready;
    logic signed [10:0]    value;
    logic [LEN_W-1:0]      pos;
    logic                  range_err;
    logic                  complete;
`ifdef INSTREAM_STALL_EN
    logic [15:0]           stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic signed [10:0] exp_q [$];

    instream #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .length    (length),
        .data      (data),
        .rd        (rd),
        .wready    (wready),
        .value     (value),
        .pos       (pos),
        .range_err (range_err),
        .complete  (complete)
`ifdef INSTREAM_STALL_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_data;
        for (int i = 0; i < DEPTH; i++) data[i] = '0;
        exp_q.delete();
    endtask

    // Drives rd (high every 'period' cycles, counted from cycle 0) until complete,
    // popping the scoreboard on every transfer.
    task automatic run_stream(input int period, input int budget,
                              output int nx, output int first_x,
                              output int last_x, output int done_cyc);
        logic signed [10:0] e;
        int cyc;
        nx = 0; first_x = -1; last_x = -1; done_cyc = -1; cyc = 0;
        while (cyc < budget && done_cyc < 0) begin
            if (complete) begin
                done_cyc = cyc;
            end else begin
                rd = (period <= 1) ? 1'b1 : ((cyc % period) == 0);
                if (wready && exp_q.size() > 0) begin
                    e = exp_q[0];
                    checks++;
                    if (value !== e) begin
                        errors++;
                        $display("FAIL value@cyc%0d: got %0d expected %0d", cyc, value, e);
                    end
                    if (rd) begin
                        void'(exp_q.pop_front());
                        checks++;
                        if (pos !== LEN_W'(nx)) begin
                            errors++;
                            $display("FAIL pos_at_xfer: got %0d expected %0d", pos, nx);
                        end
                        if (first_x < 0) first_x = cyc;
                        last_x = cyc;
                        nx++;
                    end
                end else if (wready) begin
                    errors++; checks++;
                    $display("FAIL scoreboard_empty: got wready=1 expected no offer");
                end
                tick();
                cyc++;
            end
        end
        rd = 1'b0;
    endtask

    task automatic test_reset;
        clear_data();
        length = 6'd3; rd = 1'b0;
        do_reset();
        checks += 5;
        if (wready !== 1'b0)    begin errors++; $display("FAIL rst_wready: got %b expected 0", wready); end
        if (value !== 11'sd0)   begin errors++; $display("FAIL rst_value: got %0d expected 0", value); end
        if (pos !== '0)         begin errors++; $display("FAIL rst_pos: got %0d expected 0", pos); end
        if (range_err !== 1'b0) begin errors++; $display("FAIL rst_range_err: got %b expected 0", range_err); end
        if (complete !== 1'b0)  begin errors++; $display("FAIL rst_complete: got %b expected 0", complete); end
`ifdef INSTREAM_STALL_EN
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
`endif
    endtask

    task automatic test_basic;
        int nx, fx, lx, dc;
        clear_data();
        length = 6'd3;
        data[0] = 11'sd5; data[1] = -11'sd7; data[2] = 11'sd999;
        exp_q.push_back(11'sd5); exp_q.push_back(-11'sd7); exp_q.push_back(11'sd999);
        rd = 1'b1;
        do_reset();
        run_stream(1, 20, nx, fx, lx, dc);
        checks += 6;
        if (nx !== 3)           begin errors++; $display("FAIL basic_xfers: got %0d expected 3", nx); end
        if (fx !== 1 || lx !== 3) begin errors++; $display("FAIL basic_timing: got first=%0d last=%0d expected 1,3", fx, lx); end
        if (dc !== 4)           begin errors++; $display("FAIL basic_complete_cyc: got %0d expected 4", dc); end
        if (pos !== 6'd3)       begin errors++; $display("FAIL basic_pos: got %0d expected 3", pos); end
        if (wready !== 1'b0)    begin errors++; $display("FAIL basic_wready: got %b expected 0", wready); end
        if (range_err !== 1'b0) begin errors++; $display("FAIL basic_range_err: got %b expected 0", range_err); end
    endtask

    task automatic test_empty;
        clear_data();
        length = 6'd0; rd = 1'b1;
        do_reset();
        tick();
        checks += 3;
        if (complete !== 1'b1) begin errors++; $display("FAIL empty_complete: got %b expected 1", complete); end
        if (wready !== 1'b0)   begin errors++; $display("FAIL empty_wready: got %b expected 0", wready); end
        if (pos !== '0)        begin errors++; $display("FAIL empty_pos: got %0d expected 0", pos); end
        repeat (3) tick();
        checks += 2;
        if (pos !== '0 || wready !== 1'b0) begin errors++; $display("FAIL empty_rd_ignored: got pos=%0d wready=%b expected 0,0", pos, wready); end
        if (complete !== 1'b1) begin errors++; $display("FAIL empty_hold: got %b expected 1", complete); end
        rd = 1'b0;
    endtask

    task automatic test_pulsed;
        int nx, fx, lx, dc;
        clear_data();
        length = 6'd2;
        data[0] = 11'sd12; data[1] = 11'sd34;
        exp_q.push_back(11'sd12); exp_q.push_back(11'sd34);
        rd = 1'b0;
        do_reset();
        run_stream(4, 30, nx, fx, lx, dc);
        checks += 4;
        if (fx !== 4 || lx !== 8) begin errors++; $display("FAIL pulsed_timing: got first=%0d last=%0d expected 4,8", fx, lx); end
        if (dc !== 9)             begin errors++; $display("FAIL pulsed_complete_cyc: got %0d expected 9", dc); end
        if (pos !== 6'd2)         begin errors++; $display("FAIL pulsed_pos: got %0d expected 2", pos); end
        if (value !== 11'sd34)    begin errors++; $display("FAIL pulsed_last_value: got %0d expected 34", value); end
`ifdef INSTREAM_STALL_EN
        checks++;
        if (stall_cnt !== 16'd6) begin errors++; $display("FAIL pulsed_stall: got %0d expected 6", stall_cnt); end
`endif
    endtask

    task automatic test_saturate;
        int nx, fx, lx, dc;
        clear_data();
        length = 6'd4;
        data[0] = 11'sd1023; data[1] = -11'sd1024; data[2] = 11'sd1000; data[3] = -11'sd1000;
        exp_q.push_back(11'sd999); exp_q.push_back(-11'sd999);
        exp_q.push_back(11'sd999); exp_q.push_back(-11'sd999);
        rd = 1'b0;
        do_reset();
        tick();
        checks++;
        if (range_err !== 1'b1) begin errors++; $display("FAIL sat_err_after_load: got %b expected 1", range_err); end
        run_stream(1, 20, nx, fx, lx, dc);
        checks += 3;
        if (nx !== 4)           begin errors++; $display("FAIL sat_xfers: got %0d expected 4", nx); end
        if (complete !== 1'b1)  begin errors++; $display("FAIL sat_complete: got %b expected 1", complete); end
        if (range_err !== 1'b1) begin errors++; $display("FAIL sat_err_sticky: got %b expected 1", range_err); end
    endtask

    task automatic test_overlength;
        int nx, fx, lx, dc;
        clear_data();
        length = 6'd45;
        for (int k = 0; k < DEPTH; k++) begin
            data[k] = 11'(k);
            exp_q.push_back(11'(k));
        end
        rd = 1'b1;
        do_reset();
        run_stream(1, 100, nx, fx, lx, dc);
        checks += 3;
        if (nx !== 39)        begin errors++; $display("FAIL over_xfers: got %0d expected 39", nx); end
        if (dc !== 40)        begin errors++; $display("FAIL over_complete_cyc: got %0d expected 40", dc); end
        if (pos !== 6'd39)    begin errors++; $display("FAIL over_pos: got %0d expected 39", pos); end
    endtask

    task automatic test_midreset;
        int cyc;
        clear_data();
        length = 6'd5;
        for (int k = 0; k < 5; k++) data[k] = 11'(10 * k + 3);
        rd = 1'b1;
        do_reset();
        cyc = 0;
        while (pos != 6'd2 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (pos !== 6'd2) begin errors++; $display("FAIL mid_reach_pos2: got %0d expected 2", pos); end
        tick();
        do_reset();
        checks += 3;
        if (pos !== '0)        begin errors++; $display("FAIL mid_pos: got %0d expected 0", pos); end
        if (wready !== 1'b0)   begin errors++; $display("FAIL mid_wready: got %b expected 0", wready); end
        if (complete !== 1'b0) begin errors++; $display("FAIL mid_complete: got %b expected 0", complete); end
        rd = 1'b0;
        tick();
        checks += 2;
        if (wready !== 1'b1)   begin errors++; $display("FAIL mid_reoffer: got %b expected 1", wready); end
        if (value !== 11'sd3)  begin errors++; $display("FAIL mid_value: got %0d expected 3", value); end
    endtask

    initial begin
        rst = 1'b0; rd = 1'b0; length = '0;
        for (int i = 0; i < DEPTH; i++) data[i] = '0;
        test_reset();
        test_basic();
        test_empty();
        test_pulsed();
        test_saturate();
        test_overlength();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
